// File: rtl/hazard_unit.sv
// Pipeline hazard control for the 5-stage core: execute-operand forwarding, load-use stalls,
// branch flush sequencing and memory-wait freeze. Define HAZARD_PERF_EN to add performance counters.
module hazard_unit #(
    parameter int XLEN         = 32,
    parameter int REG_AW       = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] de_rs1,
    input  logic [REG_AW-1:0] de_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [XLEN-1:0]   mem_result,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic [XLEN-1:0]   wb_value,
    input  logic [XLEN-1:0]   rb_value1,
    input  logic [XLEN-1:0]   rb_value2,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic              branch_taken,
    input  logic              mem_req,
    input  logic              mem_done,
    output logic [XLEN-1:0]   fwd_a,
    output logic [XLEN-1:0]   fwd_b,
    output logic              stall_if,
    output logic              stall_de,
    output logic              bubble_ex,
    output logic              stall_all,
    output logic              flush_if,
    output logic              flush_de,
    output logic              mem_timeout,
    output logic [1:0]        fsm_state
`ifdef HAZARD_PERF_EN
    ,
    output logic [XLEN-1:0]   perf_luh_cnt,
    output logic [XLEN-1:0]   perf_flush_cnt,
    output logic [XLEN-1:0]   perf_memwait_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic        luh;
    logic        mem_busy;

    // Memory stage wins over writeback because it holds the younger result.
    always_comb begin
        fwd_a = rb_value1;
        if (mem_reg_write && mem_rd == ex_rs1 && mem_rd != '0)
            fwd_a = mem_result;
        else if (wb_reg_write && wb_rd == ex_rs1 && wb_rd != '0)
            fwd_a = wb_value;
        fwd_b = rb_value2;
        if (mem_reg_write && mem_rd == ex_rs2 && mem_rd != '0)
            fwd_b = mem_result;
        else if (wb_reg_write && wb_rd == ex_rs2 && wb_rd != '0)
            fwd_b = wb_value;
    end

    assign luh = ex_mem_read && ex_reg_write && ex_rd != '0 &&
                 (ex_rd == de_rs1 || ex_rd == de_rs2);
    assign mem_busy  = mem_req && !mem_done;
    assign fsm_state = state;

    always_comb begin
        stall_if  = 1'b0;
        stall_de  = 1'b0;
        bubble_ex = 1'b0;
        stall_all = 1'b0;
        flush_if  = 1'b0;
        flush_de  = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (mem_busy) begin
                        stall_all = 1'b1;
                    end else if (branch_taken) begin
                        flush_if = 1'b1;
                        flush_de = 1'b1;
                    end else if (luh) begin
                        stall_if  = 1'b1;
                        stall_de  = 1'b1;
                        bubble_ex = 1'b1;
                    end
                end
                FLUSH: begin
                    if (mem_busy) begin
                        stall_all = 1'b1;
                    end else begin
                        flush_if = 1'b1;
                        flush_de = 1'b1;
                    end
                end
                MEM_WAIT: stall_all = mem_busy && (cnt < 16'(MEM_TIMEOUT));
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            cnt         <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_busy) begin
                        state <= MEM_WAIT;
                        cnt   <= 16'd1;
                    end else if (branch_taken && FLUSH_CYCLES > 1) begin
                        state <= FLUSH;
                        cnt   <= 16'd1;
                    end
                end
                FLUSH: begin
                    if (mem_busy) begin
                        state <= MEM_WAIT;
                        cnt   <= 16'd1;
                    end else if (branch_taken) begin
                        cnt <= 16'd1;
                    end else if (cnt >= 16'(FLUSH_CYCLES - 1)) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                MEM_WAIT: begin
                    if (!mem_busy) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else if (cnt >= 16'(MEM_TIMEOUT)) begin
                        mem_timeout <= 1'b1;
                        state       <= RUN;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_luh_cnt     <= '0;
            perf_flush_cnt   <= '0;
            perf_memwait_cnt <= '0;
        end else begin
            if (bubble_ex && !(&perf_luh_cnt))
                perf_luh_cnt <= perf_luh_cnt + 1'b1;
            if (flush_if && !(&perf_flush_cnt))
                perf_flush_cnt <= perf_flush_cnt + 1'b1;
            if (stall_all && !(&perf_memwait_cnt))
                perf_memwait_cnt <= perf_memwait_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: forwarding/load-use vector table plus flush, memory-wait,
// timeout and reset sequences.
module tb_hazard_unit;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   de_rs1, de_rs2, ex_rd, mem_rd, wb_rd, ex_rs1, ex_rs2;
    logic            ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write;
    logic [XLEN-1:0] mem_result, wb_value, rb_value1, rb_value2;
    logic            branch_taken, mem_req, mem_done;
    logic [XLEN-1:0] fwd_a, fwd_b;
    logic            stall_if, stall_de, bubble_ex, stall_all, flush_if, flush_de, mem_timeout;
    logic [1:0]      fsm_state;
`ifdef HAZARD_PERF_EN
    logic [XLEN-1:0] perf_luh_cnt, perf_flush_cnt, perf_memwait_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    hazard_unit #(.XLEN(XLEN), .REG_AW(AW), .FLUSH_CYCLES(2), .MEM_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .de_rs1(de_rs1), .de_rs2(de_rs2), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_value(wb_value),
        .rb_value1(rb_value1), .rb_value2(rb_value2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_done(mem_done),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_if(stall_if), .stall_de(stall_de), .bubble_ex(bubble_ex),
        .stall_all(stall_all), .flush_if(flush_if), .flush_de(flush_de),
        .mem_timeout(mem_timeout), .fsm_state(fsm_state)
`ifdef HAZARD_PERF_EN
        , .perf_luh_cnt(perf_luh_cnt), .perf_flush_cnt(perf_flush_cnt),
        .perf_memwait_cnt(perf_memwait_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]   mem_rd;
        logic            mem_rw;
        logic [AW-1:0]   wb_rd;
        logic            wb_rw;
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic [AW-1:0]   ex_rd;
        logic            ex_rw;
        logic            ex_mr;
        logic [AW-1:0]   d1;
        logic [AW-1:0]   d2;
        logic [XLEN-1:0] exp_a;
        logic [XLEN-1:0] exp_b;
        logic            exp_luh;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one cycle and land 3ns after the edge, where inputs are driven and outputs sampled.
    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic clear_inputs();
        de_rs1 = '0; de_rs2 = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
        ex_rs1 = '0; ex_rs2 = '0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; mem_reg_write = 1'b0; wb_reg_write = 1'b0;
        branch_taken = 1'b0; mem_req = 1'b0; mem_done = 1'b0;
    endtask

    task automatic set_vec(input vec_t v);
        mem_rd = v.mem_rd; mem_reg_write = v.mem_rw;
        wb_rd = v.wb_rd; wb_reg_write = v.wb_rw;
        ex_rs1 = v.rs1; ex_rs2 = v.rs2;
        ex_rd = v.ex_rd; ex_reg_write = v.ex_rw; ex_mem_read = v.ex_mr;
        de_rs1 = v.d1; de_rs2 = v.d2;
    endtask

    initial begin
        //          mem_rd rw wb_rd rw rs1 rs2 ex_rd rw mr d1 d2 exp_a    exp_b    luh
        vecs[0]  = '{5, 1, 5, 1, 5, 0, 0, 0, 0, 0, 0, 32'h11, 32'h44, 0};
        vecs[1]  = '{5, 0, 5, 1, 5, 0, 0, 0, 0, 0, 0, 32'h22, 32'h44, 0};
        vecs[2]  = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h33, 32'h44, 0};
        vecs[3]  = '{6, 1, 5, 0, 5, 6, 0, 0, 0, 0, 0, 32'h33, 32'h11, 0};
        vecs[4]  = '{7, 1, 7, 1, 9, 7, 0, 0, 0, 0, 0, 32'h33, 32'h11, 0};
        vecs[5]  = '{8, 1, 7, 1, 8, 7, 0, 0, 0, 0, 0, 32'h11, 32'h22, 0};
        vecs[6]  = '{4, 1, 4, 1, 4, 4, 0, 0, 0, 0, 0, 32'h11, 32'h11, 0};
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 3, 1, 1, 1, 3, 32'h33, 32'h44, 1};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 32'h33, 32'h44, 0};
        vecs[9]  = '{0, 0, 0, 0, 0, 0, 3, 1, 1, 3, 2, 32'h33, 32'h44, 1};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 3, 1, 0, 3, 3, 32'h33, 32'h44, 0};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 3, 0, 1, 1, 2, 32'h33, 32'h44, 0};

        mem_result = 32'h11; wb_value = 32'h22; rb_value1 = 32'h33; rb_value2 = 32'h44;
        clear_inputs();
        rst = 1'b1;
        step();
        check("rst_fwd_a", fwd_a, 32'h33);
        check("rst_stall_all", {31'd0, stall_all}, 0);
        check("rst_flush_if", {31'd0, flush_if}, 0);
        check("rst_bubble_ex", {31'd0, bubble_ex}, 0);
        check("rst_mem_timeout", {31'd0, mem_timeout}, 0);
        check("rst_state", {30'd0, fsm_state}, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 12; i++) begin
            set_vec(vecs[i]);
            #1;
            check($sformatf("v%0d_fwd_a", i), fwd_a, vecs[i].exp_a);
            check($sformatf("v%0d_fwd_b", i), fwd_b, vecs[i].exp_b);
            check($sformatf("v%0d_stall_if", i), {31'd0, stall_if}, {31'd0, vecs[i].exp_luh});
            check($sformatf("v%0d_stall_de", i), {31'd0, stall_de}, {31'd0, vecs[i].exp_luh});
            check($sformatf("v%0d_bubble_ex", i), {31'd0, bubble_ex}, {31'd0, vecs[i].exp_luh});
            check($sformatf("v%0d_stall_all", i), {31'd0, stall_all}, 0);
            step();
            check($sformatf("v%0d_state", i), {30'd0, fsm_state}, 0);
        end
        clear_inputs();
        step();

        // Single branch: two flush cycles.
        branch_taken = 1'b1; #1;
        check("br_c0_flush_if", {31'd0, flush_if}, 1);
        check("br_c0_flush_de", {31'd0, flush_de}, 1);
        step(); branch_taken = 1'b0; #1;
        check("br_c1_flush_if", {31'd0, flush_if}, 1);
        check("br_c1_state", {30'd0, fsm_state}, 1);
        step();
        check("br_c2_flush_if", {31'd0, flush_if}, 0);
        check("br_c2_state", {30'd0, fsm_state}, 0);

        // Second pulse inside the flush window extends it.
        branch_taken = 1'b1; step(); #1;
        check("br2_c1_flush_if", {31'd0, flush_if}, 1);
        step(); branch_taken = 1'b0; #1;
        check("br2_c2_flush_if", {31'd0, flush_if}, 1);
        check("br2_c2_flush_de", {31'd0, flush_de}, 1);
        step();
        check("br2_c3_flush_if", {31'd0, flush_if}, 0);

        // Memory completes after four stall cycles.
        mem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("mw_c%0d_stall_all", i), {31'd0, stall_all}, 1);
            check($sformatf("mw_c%0d_flush_if", i), {31'd0, flush_if}, 0);
            step();
        end
        mem_done = 1'b1; #1;
        check("mw_done_stall_all", {31'd0, stall_all}, 0);
        step(); mem_req = 1'b0; mem_done = 1'b0; #1;
        check("mw_after_state", {30'd0, fsm_state}, 0);
        check("mw_after_timeout", {31'd0, mem_timeout}, 0);

        // Memory stall during flush drops the rest of the flush.
        branch_taken = 1'b1; step(); branch_taken = 1'b0; mem_req = 1'b1; #1;
        check("fm_stall_all", {31'd0, stall_all}, 1);
        check("fm_flush_if", {31'd0, flush_if}, 0);
        step(); #1;
        check("fm_state", {30'd0, fsm_state}, 2);
        mem_done = 1'b1; #1;
        check("fm_done_stall_all", {31'd0, stall_all}, 0);
        step(); mem_req = 1'b0; mem_done = 1'b0; #1;
        check("fm_after_flush_if", {31'd0, flush_if}, 0);

        // Memory beats branch in the same cycle.
        mem_req = 1'b1; branch_taken = 1'b1; #1;
        check("mb_stall_all", {31'd0, stall_all}, 1);
        check("mb_flush_de", {31'd0, flush_de}, 0);
        branch_taken = 1'b0; mem_done = 1'b1;
        step(); mem_req = 1'b0; mem_done = 1'b0;
        step();

        // Timeout: eight stall cycles then sticky flag.
        mem_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("to_c%0d_stall_all", i), {31'd0, stall_all}, 1);
            step();
        end
        #1;
        check("to_release_stall_all", {31'd0, stall_all}, 0);
        check("to_release_flag", {31'd0, mem_timeout}, 0);
        step(); mem_req = 1'b0; #1;
        check("to_flag_set", {31'd0, mem_timeout}, 1);
        check("to_state", {30'd0, fsm_state}, 0);
        step(); step(); #1;
        check("to_flag_sticky", {31'd0, mem_timeout}, 1);

        // Reset two cycles into a wait.
        mem_req = 1'b1;
        step(); step(); #1;
        check("rw_state_before", {30'd0, fsm_state}, 2);
        rst = 1'b1; mem_req = 1'b0;
        step(); rst = 1'b0; #1;
        check("rw_stall_all", {31'd0, stall_all}, 0);
        check("rw_state", {30'd0, fsm_state}, 0);
        check("rw_timeout_cleared", {31'd0, mem_timeout}, 0);
`ifdef HAZARD_PERF_EN
        check("rw_perf_luh", perf_luh_cnt, 0);
        check("rw_perf_flush", perf_flush_cnt, 0);
        check("rw_perf_memwait", perf_memwait_cnt, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
